// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read per PC, PC-tagged instruction FIFO toward decode.
// Optional misaligned-PC trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int DEPTH            = 2,
    parameter bit RESET_ADDR_CHECK = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        pc_advance,
    input  logic        flush,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_fault
);

    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_req_pc;
    logic [31:0]    r_buf_data [DEPTH];
    logic [31:0]    r_buf_pc   [DEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW:0]    r_count;
    logic           r_inst_valid;
    logic [31:0]    r_inst_data;
    logic [31:0]    r_inst_pc;

    logic           w_flush;
    logic           w_misalign;
    logic           w_req_valid;
    logic           w_handshake;
    logic           w_push;
    logic           w_pop;
    logic [PW:0]    w_count_after_pop;
    logic [PW-1:0]  w_rd_nxt;

    always_comb begin
        // A redirect seen while IDLE is ignored; IDLE only lasts the cycle after reset.
        w_flush     = flush && (r_state != IDLE) && !reset;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_misalign  = (pc_in[1:0] != 2'b00);
`else
        w_misalign  = 1'b0;
`endif
        w_req_valid = (r_state == REQ) && (r_count < FULL) && !w_flush && !w_misalign && !reset;
        w_handshake = w_req_valid && imem_req_ready;
        w_push      = (r_state == WAIT) && imem_resp_valid && !w_flush;
        w_pop       = r_inst_valid && inst_ready && !w_flush;

        w_count_after_pop = r_count - (PW+1)'(w_pop);
        w_rd_nxt          = r_rd_ptr + PW'(w_pop);

        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = REQ;
            REQ:     if (w_handshake) w_state_nxt = WAIT;
            WAIT: begin
                if (imem_resp_valid)  w_state_nxt = REQ;
                else if (w_flush)     w_state_nxt = DRAIN;
            end
            DRAIN:   if (imem_resp_valid) w_state_nxt = REQ;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign pc_advance     = w_handshake | w_flush;
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = ((r_state == REQ) && !reset) ? pc_in : 32'd0;
    assign inst_valid     = r_inst_valid;
    assign inst_data      = r_inst_data;
    assign inst_pc        = r_inst_pc;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_buf_data[r_wr_ptr] <= imem_resp_data;
            r_buf_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_req_pc     <= 32'd0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_inst_valid <= 1'b0;
            r_inst_data  <= 32'd0;
            r_inst_pc    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_handshake)
                r_req_pc <= pc_in;
            if (w_flush) begin
                r_rd_ptr     <= '0;
                r_wr_ptr     <= '0;
                r_count      <= '0;
                r_inst_valid <= 1'b0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                r_rd_ptr <= w_rd_nxt;
                r_count  <= w_count_after_pop + (PW+1)'(w_push);
                // Head register: next stored entry, or the incoming word when the buffer would otherwise be empty.
                if (w_count_after_pop != '0) begin
                    r_inst_valid <= 1'b1;
                    r_inst_data  <= r_buf_data[w_rd_nxt];
                    r_inst_pc    <= r_buf_pc[w_rd_nxt];
                end else if (w_push) begin
                    r_inst_valid <= 1'b1;
                    r_inst_data  <= imem_resp_data;
                    r_inst_pc    <= r_req_pc;
                end else begin
                    r_inst_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fault;
    logic w_fault_set;

    assign w_fault_set = (r_state == REQ) && w_misalign && !w_flush && !reset;

    always_ff @(posedge clock) begin
        if (reset)
            r_fault <= 1'b0;
        else if (w_flush)
            r_fault <= 1'b0;
        else if (w_fault_set)
            r_fault <= 1'b1;
    end

    assign fetch_fault = r_fault | w_fault_set;
`else
    assign fetch_fault = 1'b0;
`endif

    generate
        if (RESET_ADDR_CHECK) begin : g_reset_addr_check
            logic r_first;
            always_ff @(posedge clock) begin
                if (reset)
                    r_first <= 1'b1;
                else if (r_inst_valid)
                    r_first <= 1'b0;
                if (!reset && r_first && r_inst_valid)
                    assert (r_inst_pc == 32'd0);
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory/decode/redirect traffic against a PC/memory reference model.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = 32'd0;
    logic        pc_advance;
    logic        flush = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        fetch_fault;

    fetch_unit #(.DEPTH(DEPTH), .RESET_ADDR_CHECK(1'b0)) dut (
        .clock           (clock),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_advance      (pc_advance),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .fetch_fault     (fetch_fault)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;

    // Reference model: PC register, single-outstanding memory, queue of fetches accepted since the last redirect.
    logic [31:0] m_pc = 32'd0;
    bit          outstanding = 1'b0;
    bit          live = 1'b0;
    int          resp_at = 0;
    logic [31:0] out_addr = 32'd0;
    logic [63:0] exp_q[$];
    int          cyc = 0;
    int          since_rst = 0;
    bit          prev_flush = 1'b0;
    bit          last_hs = 1'b0;
    logic [31:0] last_addr = 32'd0;

    int          k_mem = 100;
    int          k_dec = 100;
    int          k_flush = 0;
    int          k_dmin = 1;
    int          k_dmax = 1;
    bit          force_flush = 1'b0;
    bit          force_reset = 1'b1;
    logic [31:0] force_target = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        bit          do_flush;
        bit          hs;
        int          buffered;
        logic [31:0] tgt;
        @(negedge clock);
        reset    = force_reset;
        do_flush = !force_reset && (since_rst >= 1) &&
                   (force_flush || ($urandom_range(0, 99) < k_flush));
        tgt      = force_flush ? force_target : ($urandom_range(0, 1023) << 2);
        flush    = do_flush;
        imem_req_ready = ($urandom_range(0, 99) < k_mem);
        inst_ready     = ($urandom_range(0, 99) < k_dec);
        if (!force_reset && outstanding && (cyc >= resp_at)) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = out_addr + 32'h100;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        pc_in = m_pc;
        #1;
        hs        = imem_req_valid && imem_req_ready;
        last_hs   = hs;
        last_addr = imem_req_addr;
        buffered  = exp_q.size() - (live ? 1 : 0);

        if (force_reset) begin
            chk("pc_advance_in_reset", 32'(pc_advance), 32'd0);
        end else begin
            chk("pc_advance", 32'(pc_advance), 32'(hs || do_flush));
            if (since_rst == 0) begin
                chk("idle_pc_advance", 32'(pc_advance), 32'd0);
                chk("idle_req_valid", 32'(imem_req_valid), 32'd0);
                chk("idle_req_addr", imem_req_addr, 32'd0);
                chk("idle_inst_valid", 32'(inst_valid), 32'd0);
                chk("idle_inst_data", inst_data, 32'd0);
                chk("idle_inst_pc", inst_pc, 32'd0);
                chk("idle_fault", 32'(fetch_fault), 32'd0);
            end else if (do_flush || outstanding) begin
                chk("req_valid_quiet", 32'(imem_req_valid), 32'd0);
            end else if (m_pc[1:0] == 2'b00) begin
                chk("req_valid_issue", 32'(imem_req_valid), 32'(buffered < DEPTH));
            end
            if (imem_req_valid)
                chk("req_addr", imem_req_addr, m_pc);
            if (prev_flush)
                chk("flush_empties", 32'(inst_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
            if (!do_flush && (m_pc[1:0] == 2'b00))
                chk("fault_clear", 32'(fetch_fault), 32'd0);
`else
            chk("fault_tied_low", 32'(fetch_fault), 32'd0);
`endif
        end

        if (force_reset) begin
            m_pc        = 32'd0;
            outstanding = 1'b0;
            live        = 1'b0;
            exp_q.delete();
            since_rst   = 0;
            prev_flush  = 1'b0;
        end else begin
            if (imem_resp_valid) begin
                outstanding = 1'b0;
                live        = 1'b0;
            end
            if (do_flush) begin
                exp_q.delete();
                live = 1'b0;
                m_pc = tgt;
            end else if (hs) begin
                exp_q.push_back({m_pc + 32'h100, m_pc});
                out_addr    = imem_req_addr;
                outstanding = 1'b1;
                live        = 1'b1;
                resp_at     = cyc + int'($urandom_range(k_dmin, k_dmax));
                m_pc        = m_pc + 32'd4;
            end
            since_rst++;
            prev_flush = do_flush;
        end
        cyc++;
    endtask

    task automatic do_reset();
        force_reset = 1'b1;
        repeat (2) cycle();
        force_reset = 1'b0;
        cycle();
    endtask

    // Monitor: every instruction consumed by decode is popped from the scoreboard and compared.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clock);
            #2;
            if (!reset && !flush && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc 0x%08h data 0x%08h, expected no instruction", inst_pc, inst_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_data", inst_data, e[63:32]);
                    chk("inst_pc", inst_pc, e[31:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int first;
        int adv;
        int n;
        bit got;

        // Streaming fetch right after reset.
        force_reset = 1'b1;
        repeat (3) cycle();
        force_reset = 1'b0;
        cycle();
        first = -1;
        adv   = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (inst_valid && first < 0) first = i;
            if (pc_advance) adv++;
        end
        chk("first_valid_latency", 32'(first), 32'd2);
        chk("pc_advance_pulses", 32'(adv), 32'd4);

        // Decode stalled: buffer fills, then one pop lets the next request out.
        k_dec = 0;
        do_reset();
        n = 0;
        repeat (12) begin
            cycle();
            if (last_hs) n++;
        end
        chk("full_req_count", 32'(n), 32'd2);
        chk("full_req_quiet", 32'(imem_req_valid), 32'd0);
        k_dec = 100;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_hs) begin
                chk("addr_after_pop", last_addr, 32'h8);
                got = 1'b1;
                break;
            end
        end
        chk("req_after_pop", 32'(got), 32'd1);

        // Memory back-pressure at 0x40.
        k_mem = 0;
        repeat (4) cycle();
        force_flush  = 1'b1;
        force_target = 32'h40;
        cycle();
        force_flush = 1'b0;
        adv = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_valid_held", 32'(imem_req_valid), 32'd1);
            chk("stall_addr_held", imem_req_addr, 32'h40);
            if (pc_advance) adv++;
        end
        chk("stall_no_advance", 32'(adv), 32'd0);
        k_mem = 100;
        cycle();
        chk("accept_advance", 32'(pc_advance), 32'd1);
        chk("accept_addr", imem_req_addr, 32'h40);
        cycle();
        chk("accept_advance_once", 32'(pc_advance), 32'd0);

        // Redirect while a request is in flight and the buffer holds an entry.
        k_dec  = 0;
        k_dmin = 3;
        k_dmax = 3;
        do_reset();
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (outstanding && live && exp_q.size() == 2) begin
                got = 1'b1;
                break;
            end
        end
        chk("wait_with_entry_reached", 32'(got), 32'd1);
        force_flush  = 1'b1;
        force_target = 32'h200;
        cycle();
        force_flush = 1'b0;
        cycle();
        chk("flushed_empty", 32'(inst_valid), 32'd0);
        k_dec  = 100;
        k_dmin = 1;
        k_dmax = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (inst_valid) begin
                chk("redirect_inst_pc", inst_pc, 32'h200);
                got = 1'b1;
                break;
            end
        end
        chk("redirect_inst_seen", 32'(got), 32'd1);

        // Reset while waiting on a response.
        k_dmin = 3;
        k_dmax = 3;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (outstanding) break;
        end
        force_reset = 1'b1;
        cycle();
        force_reset = 1'b0;
        cycle();
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_pc_advance", 32'(pc_advance), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_hs) begin
                chk("restart_addr", last_addr, 32'h0);
                got = 1'b1;
                break;
            end
        end
        chk("restart_seen", 32'(got), 32'd1);

        // Random traffic with redirects and occasional resets.
        k_mem   = 70;
        k_dec   = 60;
        k_flush = 6;
        k_dmin  = 1;
        k_dmax  = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                force_reset = 1'b1;
                cycle();
                force_reset = 1'b0;
            end else begin
                cycle();
            end
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect raises the fault until the next redirect.
        k_mem   = 100;
        k_dec   = 100;
        k_flush = 0;
        k_dmin  = 1;
        k_dmax  = 1;
        do_reset();
        repeat (4) cycle();
        force_flush  = 1'b1;
        force_target = 32'h102;
        cycle();
        force_flush = 1'b0;
        repeat (3) cycle();
        chk("misalign_fault", 32'(fetch_fault), 32'd1);
        chk("misalign_no_req", 32'(imem_req_valid), 32'd0);
        chk("misalign_no_advance", 32'(pc_advance), 32'd0);
        force_flush  = 1'b1;
        force_target = 32'h104;
        cycle();
        force_flush = 1'b0;
        cycle();
        chk("misalign_fault_cleared", 32'(fetch_fault), 32'd0);
        chk("misalign_req_resumed", 32'(imem_req_valid), 32'd1);
        chk("misalign_req_addr", imem_req_addr, 32'h104);
        repeat (6) cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
